// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared processor-datapath types and constants for the sequential divider.
// Revision: 1.0
`default_nettype none

package seq_divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_W = 32;

  // The counter must reach N-1 without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/Nbit_Sub.sv
// Nbit_Sub: W-bit subtractor (result = a - b) with carry (NOT borrow), zero, negative and overflow flags.
// Revision: 1.0
`default_nettype none

module Nbit_Sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         negative,
  output logic         overflow
);

  logic [W:0] diff;

  assign diff     = {1'b0, a} - {1'b0, b};
  assign result   = diff[W-1:0];
  assign carry    = ~diff[W];
  assign zero     = (diff[W-1:0] == '0);
  assign negative = diff[W-1];
  assign overflow = (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with start/busy/done handshake.
// Revision: 1.0
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz_flag,
  output logic         zr_flag
);

  localparam int CW = cnt_width(N);

  localparam logic [1:0] ST_IDLE = DIV_IDLE;
  localparam logic [1:0] ST_RUN  = DIV_RUN;
  localparam logic [1:0] ST_DONE = DIV_DONE;

  logic [1:0]    state;
  logic [N-1:0]  q_sr;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  dvsr;
  logic [CW-1:0] cnt;

  logic [N:0]    trial;
  logic [N:0]    sub_res;
  logic          qbit;
  logic [N:0]    r_next_full;
  logic [N-1:0]  r_next;
  logic [N-1:0]  q_next;

  assign trial = {r_sr, q_sr[N-1]};

  Nbit_Sub #(
    .W(N + 1)
  ) u_sub (
    .a        (trial),
    .b        ({1'b0, dvsr}),
    .result   (sub_res),
    .carry    (qbit),
    .zero     (),
    .negative (),
    .overflow ()
  );

  // On a successful trial subtraction the difference always fits in N bits.
  assign r_next_full = qbit ? sub_res : trial;
  assign r_next      = r_next_full[N-1:0];
  assign q_next      = {q_sr[N-2:0], qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz_flag   <= 1'b0;
      zr_flag   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_sr      <= '0;
      r_sr      <= '0;
      dvsr      <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvsr  <= divisor;
              q_sr  <= dividend;
              r_sr  <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= ST_RUN;
            end else begin
              quotient  <= '1;
              remainder <= dividend;
              dz_flag   <= 1'b1;
              zr_flag   <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_sr <= r_next;
          q_sr <= q_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            quotient  <= q_next;
            remainder <= r_next;
            zr_flag   <= (q_next == '0);
            dz_flag   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (N=32).
// Revision: 1.0
`default_nettype none

module tb_seq_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dz_flag;
  logic         zr_flag;

  int compared = 0;
  int mismatched = 0;

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz_flag   (dz_flag),
    .zr_flag   (zr_flag)
  );

  always #5 clk = ~clk;

  // Issues one request from IDLE; returns the done cycle (start cycle = 0), busy count and overlap.
  // Leaves the bench one cycle after done, back in IDLE.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int dcyc, output int bcyc, output bit overlap);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    dcyc = -1; bcyc = 0; overlap = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) bcyc++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        dcyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, dz_flag, zr_flag} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got busy/done/dz/zr=%b want 0000", {busy, done, dz_flag, zr_flag});
    end
    compared++;
    if ({quotient, remainder} !== '0) begin
      mismatched++;
      $display("FAIL reset_data: got q=%h r=%h want 0/0", quotient, remainder);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, bc; bit ov;
    run_op(32'd100, 32'd7, dc, bc, ov);
    compared++;
    if (dc !== 33) begin
      mismatched++;
      $display("FAIL basic_latency: got done cycle %0d want 33", dc);
    end
    compared++;
    if (bc !== 32 || ov) begin
      mismatched++;
      $display("FAIL basic_busy: got busy cycles %0d overlap %0d want 32 / 0", bc, ov);
    end
    compared++;
    if ({quotient, remainder, zr_flag, dz_flag} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL basic_result: got q=%0d r=%0d zr=%b dz=%b want 14 2 0 0",
               quotient, remainder, zr_flag, dz_flag);
    end
  endtask

  task automatic test_boundaries();
    int dc, bc; bit ov;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, ov);
    compared++;
    if ({quotient, remainder, zr_flag} !== {32'd1, 32'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL bnd_max_max: got q=%h r=%h zr=%b want 1 0 0", quotient, remainder, zr_flag);
    end
    run_op(32'd5, 32'd9, dc, bc, ov);
    compared++;
    if ({quotient, remainder, zr_flag} !== {32'd0, 32'd5, 1'b1}) begin
      mismatched++;
      $display("FAIL bnd_small: got q=%h r=%h zr=%b want 0 5 1", quotient, remainder, zr_flag);
    end
    run_op(32'd0, 32'd7, dc, bc, ov);
    compared++;
    if ({quotient, remainder, zr_flag} !== {32'd0, 32'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL bnd_zero_dvd: got q=%h r=%h zr=%b want 0 0 1", quotient, remainder, zr_flag);
    end
    run_op(32'hDEAD_BEEF, 32'd1, dc, bc, ov);
    compared++;
    if ({quotient, remainder, zr_flag} !== {32'hDEAD_BEEF, 32'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL bnd_div1: got q=%h r=%h zr=%b want deadbeef 0 0", quotient, remainder, zr_flag);
    end
    run_op(32'h8000_0001, 32'd2, dc, bc, ov);
    compared++;
    if ({quotient, remainder} !== {32'h4000_0000, 32'd1}) begin
      mismatched++;
      $display("FAIL bnd_msb: got q=%h r=%h want 40000000 1", quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int dc, bc; bit ov;
    run_op(32'h1234, 32'd0, dc, bc, ov);
    compared++;
    if (dc !== 1 || bc !== 0) begin
      mismatched++;
      $display("FAIL dz_timing: got done cycle %0d busy cycles %0d want 1 / 0", dc, bc);
    end
    compared++;
    if ({quotient, remainder, dz_flag, zr_flag} !== {32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL dz_result: got q=%h r=%h dz=%b zr=%b want ffffffff 1234 1 0",
               quotient, remainder, dz_flag, zr_flag);
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int late_done = 0;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      start = (c == 5) || (c == 33) || (c == 34);
      dividend = (c == 34) ? 32'd50 : 32'd77 + c;
      divisor  = (c == 34) ? 32'd5  : 32'd3;
      if (done) dones++;
      if (c == 33) begin
        compared++;
        if ({done, quotient, remainder} !== {1'b1, 32'd100, 32'd0}) begin
          mismatched++;
          $display("FAIL ign_first: got done=%b q=%0d r=%0d want 1 100 0", done, quotient, remainder);
        end
      end
      if (c == 67) begin
        compared++;
        if ({done, quotient, remainder} !== {1'b1, 32'd10, 32'd0}) begin
          mismatched++;
          $display("FAIL b2b_second: got done=%b q=%0d r=%0d want 1 10 0", done, quotient, remainder);
        end
      end
      if (done && c != 33 && c != 67) late_done++;
    end
    start = 1'b0;
    compared++;
    if (dones !== 2 || late_done !== 0) begin
      mismatched++;
      $display("FAIL ign_pulses: got %0d done pulses (%0d unexpected) want 2 (0)", dones, late_done);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    int dc, bc; bit ov;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (c == 10);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    compared++;
    if ({busy, done, quotient, remainder, dz_flag, zr_flag} !== '0) begin
      mismatched++;
      $display("FAIL rstmid_state: got busy=%b done=%b q=%h r=%h dz=%b zr=%b want all 0",
               busy, done, quotient, remainder, dz_flag, zr_flag);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    compared++;
    if (stray !== 0) begin
      mismatched++;
      $display("FAIL rstmid_nodone: got %0d busy/done cycles after abort want 0", stray);
    end
    run_op(32'd9, 32'd2, dc, bc, ov);
    compared++;
    if ({quotient, remainder} !== {32'd4, 32'd1}) begin
      mismatched++;
      $display("FAIL rstmid_fresh: got q=%0d r=%0d want 4 1", quotient, remainder);
    end
  endtask

  function automatic logic [N-1:0] pick_operand(input int sel);
    case (sel)
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int dc, bc; bit ov;
    logic [N-1:0] a, b, eq, er;
    logic edz, ezr;
    for (int i = 0; i < 200; i++) begin
      a = pick_operand($urandom_range(0, 5));
      b = pick_operand($urandom_range(0, 5));
      if (i % 4 == 1) b = b >> $urandom_range(0, 31);
      if (b == '0) begin
        eq = '1; er = a; edz = 1'b1; ezr = 1'b0;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; ezr = (eq == '0);
      end
      run_op(a, b, dc, bc, ov);
      compared++;
      if ({quotient, remainder, dz_flag, zr_flag} !== {eq, er, edz, ezr} || ov) begin
        mismatched++;
        $display("FAIL rand_%0d: %h/%h got q=%h r=%h dz=%b zr=%b want q=%h r=%h dz=%b zr=%b",
                 i, a, b, quotient, remainder, dz_flag, zr_flag, eq, er, edz, ezr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
